dma_addr_seq: RTL and testbench
===============================

Name: dma_addr_seq

Overview:
State register and address sequencer for the DMA control path, sitting on both sides of the next-state/address-control decoder. It registers the decoder's active-low next-state outputs as the present state. It also executes the decoder's active-low address-control code against 2-D address counters. It returns the xskip/yskip/page/rmwb status inputs to the decoder.

Parameters:
AW, 16, address width
XW, 8, column (X) count width
YW, 8, row (Y) count width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
en  in  1  step enable; state and counters advance only when 1
cfg_we  in  1  write config shadow registers
cfg_base  in  AW  block start address
cfg_xlen  in  XW  columns per row minus one
cfg_ylen  in  YW  rows minus one
cfg_stride  in  AW  row pitch in address units
cfg_rmw  in  1  read-modify-write mode
dmnst_b  in  4  next state from decoder, active-low, bit i = dmnst{i}b
adctlp_b  in  3  address control from decoder, active-low, bit i = adctlp{i}b
dmpst  out  4  present state to decoder, bit i = dmpst{i}
rmwb  out  1  to decoder, = ~rmw shadow
xskip  out  1  X count exhausted
yskip  out  1  Y count exhausted
page  out  1  address at last word of 256-word page
addr  out  AW  current address
addr_valid  out  1  addr updated by last enabled step
done  out  1  one-cycle end-of-block pulse
err  out  1  sticky illegal control code

Behaviour:
- Reset (async, rst_n=0): dmpst=0, addr=0, row_base=0, xcnt=0, ycnt=0, all shadows=0, addr_valid=0, done=0, err=0.
- With rmw shadow=0 after reset, rmwb=1.
- Shadows load on cfg_we at posedge, independent of en.
- LOAD in the same cycle as cfg_we uses the old shadow values.
- State register: when en, dmpst <= ~dmnst_b. When en=0, dmpst holds. One-cycle latency.
- Control decode: ctl = ~adctlp_b, sampled at posedge when en=1. Actions:
  - 0 NOP: no change.
  - 1 LOAD: addr <= base; row_base <= base; xcnt <= xlen; ycnt <= ylen.
  - 2 INCX: addr <= addr+1; xcnt <= xcnt-1, saturating at 0.
  - 3 INCY: if ycnt!=0, then row_base <= row_base+stride; addr <= row_base+stride; xcnt <= xlen; ycnt <= ycnt-1. If ycnt==0, no counter or address change and done=1 for one cycle.
  - 4 PAGE: addr <= {addr[AW-1:8]+1, 8'h00}; row_base unchanged.
  - 5 WBACK: addr unchanged (RMW write-back).
  - 6, 7: treated as NOP; err <= 1, sticky until reset.
- Address arithmetic is modulo 2^AW and wraps silently. Stride and base are unsigned.
- addr_valid <= en & (ctl in 1..5). When en=0, addr_valid <= 0.
- done <= en & (ctl==3) & (ycnt==0). Otherwise done <= 0.
- Status outputs are combinational from registers only, with no path from inputs:
  - xskip = (xcnt==0)
  - yskip = (ycnt==0)
  - page = (addr[7:0]==8'hFF)
  - rmwb = ~rmw shadow
- Simultaneous events: cfg_we and a control action in the same cycle both take effect; the action uses the old shadows. dmpst and the address update in the same edge.
- Reset asserted mid-block: all registers clear immediately. The decoder sees dmpst=0 and rmwb=1 next.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> dmpst=0, addr=0, xskip=yskip=1, rmwb=1, page=0, done=0, err=0 before the next edge.
- State register: en=1, dmnst_b=4'b1010 -> dmpst=4'b0101 after one edge. en=0, dmnst_b=4'b0000 -> dmpst stays 4'b0101.
- 2-D scan: cfg base=0x0100, xlen=2, ylen=1, stride=0x0010; then LOAD, INCX, INCX, INCY, INCX, INCX, INCY (ctl via adctlp_b=~ctl).
  - Expected addr: 0x100, 0x101, 0x102, 0x110, 0x111, 0x112.
  - xskip=1 after the second INCX of each row; yskip=1 after the first INCY.
  - The final INCY pulses done for one cycle; addr stays 0x112.
- Page boundary: base=0x12FE, LOAD, INCX -> addr=0x12FF, page=1. PAGE -> addr=0x1300, page=0. Base=0xFFFF, LOAD, INCX -> addr=0x0000 (wrap).
- Config/control collision: shadows base=0x0040; cfg_we with cfg_base=0x0080 in the same cycle as LOAD -> addr=0x0040. A second LOAD -> addr=0x0080.
- Illegal code: adctlp_b=3'b001 (ctl=6) -> addr unchanged, addr_valid=0, err=1. Err stays 1 through subsequent legal steps until rst_n=0. cfg_rmw=1 -> rmwb=0 next cycle.

Source files
------------

// File: rtl/dma_addr_seq.sv
// dma_addr_seq
//   Present-state register and 2-D address sequencer for the DMA control path.
//   The next-state/address-control decoder drives active-low next-state and
//   address-control codes into this block. This block registers the state,
//   runs the address-control code against the X/Y counters, and returns
//   status flags to the decoder.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   en                step enable; state, counters and address move only when 1
//   cfg_we            load the configuration shadows (independent of en)
//   cfg_base          block start address
//   cfg_xlen          columns per row minus one
//   cfg_ylen          rows minus one
//   cfg_stride        row pitch in address units
//   cfg_rmw           read-modify-write mode
//   dmnst_b           next state from the decoder (active-low)
//   adctlp_b          address control from the decoder (active-low)
//   dmpst             present state to the decoder
//   rmwb              inverted rmw shadow, to the decoder
//   xskip, yskip      X / Y count exhausted
//   page              address sits on the last word of a 256-word page
//   addr              current address
//   addr_valid        addr was updated by the last enabled step
//   done              one-cycle end-of-block pulse
//   err               sticky flag for an illegal control code
module dma_addr_seq #(
    parameter int unsigned AW = 16,
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_base,
    input  logic [XW-1:0] cfg_xlen,
    input  logic [YW-1:0] cfg_ylen,
    input  logic [AW-1:0] cfg_stride,
    input  logic          cfg_rmw,
    input  logic [3:0]    dmnst_b,
    input  logic [2:0]    adctlp_b,
    output logic [3:0]    dmpst,
    output logic          rmwb,
    output logic          xskip,
    output logic          yskip,
    output logic          page,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        CTL_NOP   = 3'd0,
        CTL_LOAD  = 3'd1,
        CTL_INCX  = 3'd2,
        CTL_INCY  = 3'd3,
        CTL_PAGE  = 3'd4,
        CTL_WBACK = 3'd5,
        CTL_RSV6  = 3'd6,
        CTL_RSV7  = 3'd7
    } ctl_e;

    // Configuration shadows
    logic [AW-1:0] base_sh;
    logic [XW-1:0] xlen_sh;
    logic [YW-1:0] ylen_sh;
    logic [AW-1:0] stride_sh;
    logic          rmw_sh;

    // Sequencer registers
    logic [AW-1:0] row_base;
    logic [XW-1:0] xcnt;
    logic [YW-1:0] ycnt;

    ctl_e          ctl;
    logic [AW-1:0] next_row;

    assign ctl      = ctl_e'(~adctlp_b);
    assign next_row = row_base + stride_sh;

    // Shadows load on cfg_we regardless of en. A control action in the same
    // edge reads the values held before this write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_sh   <= '0;
            xlen_sh   <= '0;
            ylen_sh   <= '0;
            stride_sh <= '0;
            rmw_sh    <= 1'b0;
        end else if (cfg_we) begin
            base_sh   <= cfg_base;
            xlen_sh   <= cfg_xlen;
            ylen_sh   <= cfg_ylen;
            stride_sh <= cfg_stride;
            rmw_sh    <= cfg_rmw;
        end
    end

    // Present-state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmpst <= '0;
        end else if (en) begin
            dmpst <= ~dmnst_b;
        end
    end

    // Address sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            row_base   <= '0;
            xcnt       <= '0;
            ycnt       <= '0;
            addr_valid <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            addr_valid <= 1'b0;
            done       <= 1'b0;
            if (en) begin
                case (ctl)
                    CTL_LOAD: begin
                        addr       <= base_sh;
                        row_base   <= base_sh;
                        xcnt       <= xlen_sh;
                        ycnt       <= ylen_sh;
                        addr_valid <= 1'b1;
                    end
                    CTL_INCX: begin
                        addr       <= addr + AW'(1);
                        xcnt       <= (xcnt == '0) ? '0 : xcnt - XW'(1);
                        addr_valid <= 1'b1;
                    end
                    CTL_INCY: begin
                        addr_valid <= 1'b1;
                        // Last row already consumed: hold everything and
                        // signal end of block instead of advancing.
                        if (ycnt != '0) begin
                            row_base <= next_row;
                            addr     <= next_row;
                            xcnt     <= xlen_sh;
                            ycnt     <= ycnt - YW'(1);
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    CTL_PAGE: begin
                        addr       <= {addr[AW-1:8] + (AW-8)'(1), 8'h00};
                        addr_valid <= 1'b1;
                    end
                    CTL_WBACK: begin
                        addr_valid <= 1'b1;
                    end
                    CTL_RSV6, CTL_RSV7: begin
                        err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Status back to the decoder, from registers only
    assign xskip = (xcnt == '0);
    assign yskip = (ycnt == '0);
    assign page  = (addr[7:0] == 8'hFF);
    assign rmwb  = ~rmw_sh;

endmodule

// File: tb/tb_dma_addr_seq.sv
module tb_dma_addr_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cfg_we;
    logic [15:0] cfg_base;
    logic [7:0]  cfg_xlen;
    logic [7:0]  cfg_ylen;
    logic [15:0] cfg_stride;
    logic        cfg_rmw;
    logic [3:0]  dmnst_b;
    logic [2:0]  adctlp_b;
    logic [3:0]  dmpst;
    logic        rmwb;
    logic        xskip;
    logic        yskip;
    logic        page;
    logic [15:0] addr;
    logic        addr_valid;
    logic        done;
    logic        err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    dma_addr_seq #(.AW(16), .XW(8), .YW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_base   (cfg_base),
        .cfg_xlen   (cfg_xlen),
        .cfg_ylen   (cfg_ylen),
        .cfg_stride (cfg_stride),
        .cfg_rmw    (cfg_rmw),
        .dmnst_b    (dmnst_b),
        .adctlp_b   (adctlp_b),
        .dmpst      (dmpst),
        .rmwb       (rmwb),
        .xskip      (xskip),
        .yskip      (yskip),
        .page       (page),
        .addr       (addr),
        .addr_valid (addr_valid),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One enabled step with control code ctl; returns #1 after the edge.
    task automatic step(input logic [2:0] ctl);
        @(negedge clk);
        en       = 1'b1;
        adctlp_b = ~ctl;
        @(posedge clk);
        #1;
        en       = 1'b0;
        adctlp_b = 3'b111;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [15:0] b, input logic [7:0] xl, input logic [7:0] yl,
                             input logic [15:0] st, input logic rmw);
        @(negedge clk);
        en         = 1'b0;
        cfg_we     = 1'b1;
        cfg_base   = b;
        cfg_xlen   = xl;
        cfg_ylen   = yl;
        cfg_stride = st;
        cfg_rmw    = rmw;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        cfg_we     = 1'b0;
        cfg_base   = '0;
        cfg_xlen   = '0;
        cfg_ylen   = '0;
        cfg_stride = '0;
        cfg_rmw    = 1'b0;
        dmnst_b    = 4'hF;
        adctlp_b   = 3'b111;
        #12;
        check("rst_addr",  32'(addr), 32'h0);
        check("rst_rmwb",  32'(rmwb), 32'h1);
        check("rst_xskip", 32'(xskip), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // State register
        dmnst_b = 4'b1010;
        step(3'd0);
        check("dmpst_load", 32'(dmpst), 32'h5);
        dmnst_b = 4'b0000;
        idle();
        check("dmpst_hold", 32'(dmpst), 32'h5);
        dmnst_b = 4'hF;

        // 2-D scan
        cfg_write(16'h0100, 8'd2, 8'd1, 16'h0010, 1'b0);
        step(3'd1);
        check("scan_load",  32'(addr), 32'h100);
        check("scan_av",    32'(addr_valid), 32'h1);
        check("scan_xs0",   32'(xskip), 32'h0);
        check("scan_ys0",   32'(yskip), 32'h0);
        step(3'd2);
        check("scan_x1",    32'(addr), 32'h101);
        check("scan_xs1",   32'(xskip), 32'h0);
        step(3'd2);
        check("scan_x2",    32'(addr), 32'h102);
        check("scan_xs2",   32'(xskip), 32'h1);
        step(3'd3);
        check("scan_y1",    32'(addr), 32'h110);
        check("scan_ys1",   32'(yskip), 32'h1);
        check("scan_xs3",   32'(xskip), 32'h0);
        check("scan_done0", 32'(done), 32'h0);
        step(3'd2);
        check("scan_x3",    32'(addr), 32'h111);
        step(3'd2);
        check("scan_x4",    32'(addr), 32'h112);
        check("scan_xs4",   32'(xskip), 32'h1);
        step(3'd3);
        check("scan_done",  32'(done), 32'h1);
        check("scan_hold",  32'(addr), 32'h112);
        step(3'd0);
        check("scan_done_pulse", 32'(done), 32'h0);
        check("scan_nop_av",     32'(addr_valid), 32'h0);

        // Page boundary and wrap
        cfg_write(16'h12FE, 8'd5, 8'd0, 16'h0000, 1'b0);
        step(3'd1);
        check("pg_load",  32'(page), 32'h0);
        step(3'd2);
        check("pg_addr",  32'(addr), 32'h12FF);
        check("pg_flag",  32'(page), 32'h1);
        step(3'd4);
        check("pg_next",  32'(addr), 32'h1300);
        check("pg_clear", 32'(page), 32'h0);
        cfg_write(16'hFFFF, 8'd5, 8'd0, 16'h0000, 1'b0);
        step(3'd1);
        check("wrap_load", 32'(addr), 32'hFFFF);
        step(3'd2);
        check("wrap_addr", 32'(addr), 32'h0000);
        step(3'd5);
        check("wback_addr", 32'(addr), 32'h0000);
        check("wback_av",   32'(addr_valid), 32'h1);

        // Config/control collision
        cfg_write(16'h0040, 8'd3, 8'd3, 16'h0008, 1'b0);
        @(negedge clk);
        en       = 1'b1;
        adctlp_b = ~3'd1;
        cfg_we   = 1'b1;
        cfg_base = 16'h0080;
        @(posedge clk);
        #1;
        en       = 1'b0;
        cfg_we   = 1'b0;
        adctlp_b = 3'b111;
        check("coll_old", 32'(addr), 32'h0040);
        step(3'd1);
        check("coll_new", 32'(addr), 32'h0080);

        // Illegal code
        check("err_pre",  32'(err), 32'h0);
        step(3'd6);
        check("ill_addr", 32'(addr), 32'h0080);
        check("ill_av",   32'(addr_valid), 32'h0);
        check("ill_err",  32'(err), 32'h1);
        step(3'd2);
        check("ill_sticky", 32'(err), 32'h1);
        check("ill_next",   32'(addr), 32'h0081);
        cfg_write(16'h0080, 8'd3, 8'd3, 16'h0008, 1'b1);
        check("rmwb_on", 32'(rmwb), 32'h0);

        // Asynchronous reset mid-cycle, mid-block
        dmnst_b = 4'b0011;
        step(3'd2);
        check("pre_rst_dmpst", 32'(dmpst), 32'hC);
        dmnst_b = 4'hF;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_dmpst", 32'(dmpst), 32'h0);
        check("arst_addr",  32'(addr), 32'h0);
        check("arst_xskip", 32'(xskip), 32'h1);
        check("arst_yskip", 32'(yskip), 32'h1);
        check("arst_rmwb",  32'(rmwb), 32'h1);
        check("arst_page",  32'(page), 32'h0);
        check("arst_done",  32'(done), 32'h0);
        check("arst_err",   32'(err), 32'h0);
        check("arst_av",    32'(addr_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
